fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the Ra8 core, directly upstream of the pipeline block.
//  Walks a 16-bit PC, reads bytes over a req/ack memory port and assembles
//  opcode + 0..3 operand bytes into one instruction packet.
//  Hands the packet to the pipeline with valid/ready; freezes when the pipeline mutex is held.
// PARAMETERS
//  ADDR_W    16       PC / memory address width
//  RESET_PC  16'h0000 PC value loaded on reset
// PORTS
//  clk            in   1       core clock, all state updates on posedge
//  reset          in   1       asynchronous, active-low reset
//  stall          in   1       pipeline mutexStatus; 1 = do not hand off
//  redirect_valid in   1       branch/jump taken; flush and refetch
//  redirect_addr  in   ADDR_W  new PC on redirect
//  mem_req        out  1       memory read request
//  mem_addr       out  ADDR_W  byte address of request
//  mem_ack        in   1       read data valid this cycle
//  mem_rdata      in   8       read data byte
//  instr_valid    out  1       packet below is complete
//  instr_ready    in   1       pipeline accepts packet
//  instr_opcode   out  8       opcode byte (pipeline 'instruction')
//  instr_opnd     out  24      operand bytes {op3,op2,op1}; unused bytes = 0
//  instr_len      out  2       number of operand bytes (= opcode[7:6])
//  instr_pc       out  ADDR_W  address of the opcode byte
// BEHAVIOUR
//  - Reset (async, reset==0): state=S_OP, pc=RESET_PC, mem_req=0, instr_valid=0,
//    instr_opcode/opnd/len=0, instr_pc=RESET_PC, flush=0. mem_req rises first clk after release.
//  - Memory handshake: mem_req held 1 with stable mem_addr until a posedge samples mem_ack=1;
//    mem_rdata captured on that edge. Zero-wait memory may ack in the cycle req is high.
//  - pc increments by 1 per accepted byte, wraps FFFF->0000 (modulo 2^ADDR_W).
//  - FSM:
//    S_OP:   req at pc; on ack latch opcode, instr_pc=pc, cnt=opcode[7:6];
//            cnt==0 -> S_HOLD else -> S_OPND.
//    S_OPND: req at pc; on ack store byte at operand index (len-cnt), cnt--; cnt hits 0 -> S_HOLD.
//    S_HOLD: mem_req=0, instr_valid=1; handoff when instr_valid & instr_ready & !stall
//            -> instr_valid=0 next cycle, -> S_OP.
//  - Latency: 1-byte instr, zero-wait memory: req cycle N, valid cycle N+1, next req N+2
//    (no overlap); n-byte instr valid n cycles after first req.
//  - Outputs stable while instr_valid=1 and not handed off; stall=1 holds S_HOLD indefinitely.
//  - stall does not block S_OP/S_OPND fetching; it only blocks handoff.
//  - redirect_valid (highest priority, any state): pc=redirect_addr, instr_valid=0 next cycle,
//    partial packet discarded, operands cleared. If mem_req is high without ack that cycle,
//    set flush: keep req at old addr until ack, discard data, then fetch at new pc in S_OP.
//    Redirect on the same cycle as a handoff: handoff counts, next fetch uses redirect_addr.
//    Redirect while flush=1: latest redirect_addr wins.
//  - Operand byte with ack in the same cycle as redirect is discarded.
// CONFIGURATION
//  FETCH_STALL_CNT_EN defined: adds output stall_cycles [15:0], counts cycles with
//    instr_valid & stall; saturates at FFFF; reset to 0; cleared on redirect.
//  Not defined: port absent, no counter logic.
// TESTING
//  1 Reset release, mem={8'h05}, ack same cycle -> mem_addr=0000, instr_valid cycle 2,
//    opcode=05, len=0, opnd=0, instr_pc=0000.
//  2 3-operand instr mem[10..13]={C1,AA,BB,CC} -> valid after 4 acks,
//    opnd=24'hCCBBAA, len=3, pc=0014.
//  3 Packet valid, stall=1 for 5 cycles with instr_ready=1 -> packet held, no mem_req;
//    stall=0 -> handoff 1 cycle later; with FETCH_STALL_CNT_EN stall_cycles=5.
//  4 Redirect to 0x2000 while S_OPND with 2-wait-state ack pending -> old ack data dropped,
//    next req addr 2000, no packet from old address emitted.
//  5 PC at FFFF, opcode 40 (1 operand) -> operand fetched from 0000, next opcode at 0001.
//  6 Reset asserted mid-S_OPND -> mem_req and instr_valid drop immediately (async);
//    fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Ra8 instruction fetch: byte reads over req/ack, packet handoff over valid/ready
// Define FETCH_STALL_CNT_EN to add the stall_cycles counter output.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [23:0]       instr_opnd,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  typedef enum logic [1:0] {S_OP, S_OPND, S_HOLD} stateT;

  stateT             state, stateNext;
  logic [ADDR_W-1:0] pc, pcNext;
  logic [ADDR_W-1:0] memAddrQ, addrNext;
  logic              memReqQ, reqNext;
  logic              flush, flushNext;
  logic [1:0]        cnt, cntNext;
  logic [7:0]        opcodeQ, opcodeNext;
  logic [23:0]       opndQ, opndNext;
  logic [1:0]        lenQ, lenNext;
  logic [ADDR_W-1:0] instrPcQ, instrPcNext;
  logic              validQ, validNext;

  logic              accept;
  logic              handoff;
  logic [ADDR_W-1:0] pcInc;
  logic [1:0]        opndIdx;

  assign accept  = memReqQ & mem_ack;
  assign handoff = validQ & instr_ready & ~stall;
  assign pcInc   = pc + ADDR_W'(1);
  assign opndIdx = lenQ - cnt;

  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    addrNext    = memAddrQ;
    reqNext     = memReqQ;
    flushNext   = flush;
    cntNext     = cnt;
    opcodeNext  = opcodeQ;
    opndNext    = opndQ;
    lenNext     = lenQ;
    instrPcNext = instrPcQ;
    validNext   = validQ;

    if (redirect_valid) begin
      stateNext = S_OP;
      pcNext    = redirect_addr;
      validNext = 1'b0;
      opndNext  = '0;
      cntNext   = '0;
      // An unacknowledged read cannot be withdrawn; let it finish and drop its data.
      if (memReqQ && !mem_ack) begin
        flushNext = 1'b1;
      end else begin
        flushNext = 1'b0;
        reqNext   = 1'b1;
        addrNext  = redirect_addr;
      end
    end else if (flush) begin
      if (accept) begin
        flushNext = 1'b0;
        addrNext  = pc;
      end
    end else begin
      case (state)
        S_OP: begin
          if (!memReqQ) begin
            reqNext  = 1'b1;
            addrNext = pc;
          end else if (mem_ack) begin
            opcodeNext  = mem_rdata;
            instrPcNext = pc;
            lenNext     = mem_rdata[7:6];
            cntNext     = mem_rdata[7:6];
            opndNext    = '0;
            pcNext      = pcInc;
            if (mem_rdata[7:6] == 2'd0) begin
              stateNext = S_HOLD;
              reqNext   = 1'b0;
              validNext = 1'b1;
            end else begin
              stateNext = S_OPND;
              addrNext  = pcInc;
            end
          end
        end
        S_OPND: begin
          if (accept) begin
            case (opndIdx)
              2'd0:    opndNext[7:0]   = mem_rdata;
              2'd1:    opndNext[15:8]  = mem_rdata;
              default: opndNext[23:16] = mem_rdata;
            endcase
            cntNext = cnt - 2'd1;
            pcNext  = pcInc;
            if (cnt == 2'd1) begin
              stateNext = S_HOLD;
              reqNext   = 1'b0;
              validNext = 1'b1;
            end else begin
              addrNext = pcInc;
            end
          end
        end
        S_HOLD: begin
          if (handoff) begin
            validNext = 1'b0;
            stateNext = S_OP;
            reqNext   = 1'b1;
            addrNext  = pc;
          end
        end
        default: stateNext = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_OP;
      pc       <= RESET_PC;
      memAddrQ <= RESET_PC;
      memReqQ  <= 1'b0;
      flush    <= 1'b0;
      cnt      <= '0;
      opcodeQ  <= '0;
      opndQ    <= '0;
      lenQ     <= '0;
      instrPcQ <= RESET_PC;
      validQ   <= 1'b0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      memAddrQ <= addrNext;
      memReqQ  <= reqNext;
      flush    <= flushNext;
      cnt      <= cntNext;
      opcodeQ  <= opcodeNext;
      opndQ    <= opndNext;
      lenQ     <= lenNext;
      instrPcQ <= instrPcNext;
      validQ   <= validNext;
    end
  end

  assign mem_req      = memReqQ;
  assign mem_addr     = memAddrQ;
  assign instr_valid  = validQ;
  assign instr_opcode = opcodeQ;
  assign instr_opnd   = opndQ;
  assign instr_len    = lenQ;
  assign instr_pc     = instrPcQ;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stallCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= '0;
    end else if (redirect_valid) begin
      stallCnt <= '0;
    end else if (validQ && stall && (stallCnt != 16'hFFFF)) begin
      stallCnt <= stallCnt + 16'd1;
    end
  end

  assign stall_cycles = stallCnt;
`endif

endmodule
